// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared constants and types for the two-port RAM arbiter.
//   - RAM_ADDR_WIDTH / RAM_DATA_WIDTH : default RAM word-address and data widths
//   - owner_e                         : requester identity (A=0, B=1), used for
//                                       the last-grant and read-owner registers
package ram_arbiter_pkg;

  localparam int RAM_ADDR_WIDTH = 13;
  localparam int RAM_DATA_WIDTH = 8;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the two requester ports and the single-port RAM command port.
//   Ports (per requester x in {a, b}):
//     io_x_rd, io_x_wr     : read / write strobes, held until acknowledged
//     io_x_addr, io_x_din  : address and write data
//     io_x_ack             : command accepted this cycle
//     io_x_valid, io_x_dout: read data strobe and data
//   RAM side:
//     io_ram_rd, io_ram_wr, io_ram_addr, io_ram_din : command to the RAM
//     io_ram_dout                                   : RAM read data (1-cycle latency)
//   Modports: slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = ram_arbiter_pkg::RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_arbiter_pkg::RAM_DATA_WIDTH
);

  logic                  io_a_rd;
  logic                  io_a_wr;
  logic [ADDR_WIDTH-1:0] io_a_addr;
  logic [DATA_WIDTH-1:0] io_a_din;
  logic                  io_a_ack;
  logic                  io_a_valid;
  logic [DATA_WIDTH-1:0] io_a_dout;

  logic                  io_b_rd;
  logic                  io_b_wr;
  logic [ADDR_WIDTH-1:0] io_b_addr;
  logic [DATA_WIDTH-1:0] io_b_din;
  logic                  io_b_ack;
  logic                  io_b_valid;
  logic [DATA_WIDTH-1:0] io_b_dout;

  logic                  io_ram_rd;
  logic                  io_ram_wr;
  logic [ADDR_WIDTH-1:0] io_ram_addr;
  logic [DATA_WIDTH-1:0] io_ram_din;
  logic [DATA_WIDTH-1:0] io_ram_dout;

  modport slave (
    input  io_a_rd, io_a_wr, io_a_addr, io_a_din,
    output io_a_ack, io_a_valid, io_a_dout,
    input  io_b_rd, io_b_wr, io_b_addr, io_b_din,
    output io_b_ack, io_b_valid, io_b_dout,
    output io_ram_rd, io_ram_wr, io_ram_addr, io_ram_din,
    input  io_ram_dout
  );

  modport master (
    output io_a_rd, io_a_wr, io_a_addr, io_a_din,
    input  io_a_ack, io_a_valid, io_a_dout,
    output io_b_rd, io_b_wr, io_b_addr, io_b_din,
    input  io_b_ack, io_b_valid, io_b_dout,
    input  io_ram_rd, io_ram_wr, io_ram_addr, io_ram_din,
    output io_ram_dout
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-way arbiter: round-robin by default, or fixed priority to A when
//   PRIORITY_A != 0. Grants are combinational on the requests and the
//   registered last_grant.
//   Ports:
//     clock, reset   : clock and asynchronous active-low reset
//     req_a, req_b   : requester pending
//     gnt_a, gnt_b   : one-hot-or-zero grant
module rr_arbiter2
  import ram_arbiter_pkg::*;
#(
  parameter int PRIORITY_A = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  owner_e last_grant_q;
  owner_e last_grant_d;

  // Grants are held off while reset is low so no ack can leak out during reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset) begin
      if (PRIORITY_A != 0) begin
        gnt_a = req_a;
        gnt_b = req_b & ~req_a;
      end else if (req_a && req_b) begin
        gnt_a = (last_grant_q == OWNER_B);
        gnt_b = ~gnt_a;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_a) begin
      last_grant_d = OWNER_A;
    end else if (gnt_b) begin
      last_grant_d = OWNER_B;
    end
  end

  // Resetting to B means A wins the first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= OWNER_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between requesters A and B. The winner's
//   command is forwarded to the RAM in the grant cycle; read data returns
//   one cycle later and is flagged with a valid pulse to the read's owner.
//   Ports:
//     clock : clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : ram_arbiter_if slave modport (requesters A/B and RAM command)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int PRIORITY_A = 0
) (
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  logic                  pend_a;
  logic                  pend_b;
  logic                  gnt_a;
  logic                  gnt_b;

  logic                  ram_rd;
  logic                  ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  logic                  rd_pending_q;
  logic                  rd_pending_d;
  owner_e                rd_owner_q;
  owner_e                rd_owner_d;

  assign pend_a = bus.io_a_rd | bus.io_a_wr;
  assign pend_b = bus.io_b_rd | bus.io_b_wr;

  rr_arbiter2 #(
    .PRIORITY_A (PRIORITY_A)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .req_a (pend_a),
    .req_b (pend_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Command mux. A simultaneous rd+wr is issued as a write only.
  always_comb begin
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_a) begin
      ram_wr   = bus.io_a_wr;
      ram_rd   = bus.io_a_rd & ~bus.io_a_wr;
      ram_addr = bus.io_a_addr;
      ram_din  = bus.io_a_din;
    end else if (gnt_b) begin
      ram_wr   = bus.io_b_wr;
      ram_rd   = bus.io_b_rd & ~bus.io_b_wr;
      ram_addr = bus.io_b_addr;
      ram_din  = bus.io_b_din;
    end
  end

  always_comb begin
    rd_pending_d = ram_rd;
    rd_owner_d   = rd_owner_q;
    if (ram_rd) begin
      rd_owner_d = gnt_b ? OWNER_B : OWNER_A;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWNER_A;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign bus.io_ram_rd   = ram_rd;
  assign bus.io_ram_wr   = ram_wr;
  assign bus.io_ram_addr = ram_addr;
  assign bus.io_ram_din  = ram_din;

  assign bus.io_a_ack    = gnt_a;
  assign bus.io_b_ack    = gnt_b;

  // Valid is a decode of registered state, so it is a clean one-cycle pulse.
  assign bus.io_a_valid  = rd_pending_q & (rd_owner_q == OWNER_A);
  assign bus.io_b_valid  = rd_pending_q & (rd_owner_q == OWNER_B);

  // Data is passed through unqualified; consumers use valid.
  assign bus.io_a_dout   = bus.io_ram_dout;
  assign bus.io_b_dout   = bus.io_ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter: one round-robin instance (br) and one
//   fixed-priority instance (bf), each backed by a simple 1-cycle RAM model.
module tb_ram_arbiter;

  logic clock;
  logic reset;

  int n_vec;
  int n_err;

  ram_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) br ();
  ram_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bf ();

  ram_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .PRIORITY_A(0)) dut_rr (
    .clock (clock),
    .reset (reset),
    .bus   (br)
  );

  ram_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .PRIORITY_A(1)) dut_fp (
    .clock (clock),
    .reset (reset),
    .bus   (bf)
  );

  logic [7:0] mem_r [0:8191];
  logic [7:0] mem_f [0:8191];
  logic [7:0] rdat_r;
  logic [7:0] rdat_f;

  always @(posedge clock) begin
    if (br.io_ram_wr) mem_r[br.io_ram_addr] <= br.io_ram_din;
    if (br.io_ram_rd) rdat_r <= mem_r[br.io_ram_addr];
    if (bf.io_ram_wr) mem_f[bf.io_ram_addr] <= bf.io_ram_din;
    if (bf.io_ram_rd) rdat_f <= mem_f[bf.io_ram_addr];
  end

  assign br.io_ram_dout = rdat_r;
  assign bf.io_ram_dout = rdat_f;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle_all();
    br.io_a_rd = 0; br.io_a_wr = 0; br.io_a_addr = '0; br.io_a_din = '0;
    br.io_b_rd = 0; br.io_b_wr = 0; br.io_b_addr = '0; br.io_b_din = '0;
    bf.io_a_rd = 0; bf.io_a_wr = 0; bf.io_a_addr = '0; bf.io_a_din = '0;
    bf.io_b_rd = 0; bf.io_b_wr = 0; bf.io_b_addr = '0; bf.io_b_din = '0;
  endtask

  task automatic set_a(input logic rd, input logic wr, input logic [12:0] addr, input logic [7:0] din);
    br.io_a_rd = rd; br.io_a_wr = wr; br.io_a_addr = addr; br.io_a_din = din;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [12:0] addr, input logic [7:0] din);
    br.io_b_rd = rd; br.io_b_wr = wr; br.io_b_addr = addr; br.io_b_din = din;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    idle_all();

    // Reset state: strobes high during reset must not produce acks or RAM commands.
    tick();
    br.io_a_rd = 1; bf.io_b_wr = 1;
    settle();
    chk("rst_a_ack",   32'(br.io_a_ack),   0);
    chk("rst_ram_rd",  32'(br.io_ram_rd),  0);
    chk("rst_a_valid", 32'(br.io_a_valid), 0);
    chk("rst_b_valid", 32'(br.io_b_valid), 0);
    chk("rst_fp_ack",  32'(bf.io_b_ack),   0);
    chk("rst_fp_wr",   32'(bf.io_ram_wr),  0);

    // A write 0x5A @0x0010 then read it back.
    tick();
    reset = 1'b1;
    idle_all();
    set_a(0, 1, 13'h0010, 8'h5A);
    settle();
    chk("w_a_ack",   32'(br.io_a_ack),    1);
    chk("w_b_ack",   32'(br.io_b_ack),    0);
    chk("w_ram_wr",  32'(br.io_ram_wr),   1);
    chk("w_ram_rd",  32'(br.io_ram_rd),   0);
    chk("w_addr",    32'(br.io_ram_addr), 32'h0010);
    chk("w_din",     32'(br.io_ram_din),  32'h5A);
    tick();
    set_a(1, 0, 13'h0010, 8'h00);
    settle();
    chk("r_a_ack",   32'(br.io_a_ack),    1);
    chk("r_ram_rd",  32'(br.io_ram_rd),   1);
    chk("r_valid0",  32'(br.io_a_valid),  0);
    tick();
    set_a(0, 0, 13'h0000, 8'h00);
    settle();
    chk("idle_ram_rd",   32'(br.io_ram_rd),   0);
    chk("idle_ram_addr", 32'(br.io_ram_addr), 0);
    chk("r_a_valid",     32'(br.io_a_valid),  1);
    chk("r_a_dout",      32'(br.io_a_dout),   32'h5A);
    chk("r_b_valid",     32'(br.io_b_valid),  0);
    tick();
    settle();
    chk("r_a_valid_end", 32'(br.io_a_valid),  0);

    // Preload B data, leave last_grant=A, then reset so only reset sets it to B.
    tick();
    set_b(0, 1, 13'h0020, 8'hA5);
    settle();
    chk("pre_b_ack", 32'(br.io_b_ack), 1);
    tick();
    set_b(0, 0, 13'h0000, 8'h00);
    set_a(0, 1, 13'h0010, 8'h5A);
    settle();
    tick();
    idle_all();
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Both reading continuously: A,B,A,B with valids one cycle behind.
    set_a(1, 0, 13'h0010, 8'h00);
    set_b(1, 0, 13'h0020, 8'h00);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("rr_a_ack%0d", k), 32'(br.io_a_ack), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_ack%0d", k), 32'(br.io_b_ack), (k % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_addr%0d", k),  32'(br.io_ram_addr), (k % 2 == 0) ? 32'h10 : 32'h20);
      if (k > 0) begin
        chk($sformatf("rr_a_val%0d", k), 32'(br.io_a_valid), (k % 2 == 1) ? 1 : 0);
        chk($sformatf("rr_b_val%0d", k), 32'(br.io_b_valid), (k % 2 == 0) ? 1 : 0);
        chk($sformatf("rr_dout%0d", k),  32'(br.io_a_dout),  (k % 2 == 1) ? 32'h5A : 32'hA5);
      end
      tick();
    end
    idle_all();
    settle();
    chk("rr_a_val_last", 32'(br.io_a_valid), 1);
    chk("rr_dout_last",  32'(br.io_b_dout),  32'h5A);

    // rd+wr together at 0x1FFF: write wins, no valid.
    tick();
    set_a(1, 1, 13'h1FFF, 8'hC3);
    settle();
    chk("rw_a_ack",  32'(br.io_a_ack),    1);
    chk("rw_ram_wr", 32'(br.io_ram_wr),   1);
    chk("rw_ram_rd", 32'(br.io_ram_rd),   0);
    chk("rw_addr",   32'(br.io_ram_addr), 32'h1FFF);
    tick();
    set_a(0, 0, 13'h0000, 8'h00);
    settle();
    chk("rw_no_valid", 32'(br.io_a_valid), 0);
    tick();
    set_a(1, 0, 13'h1FFF, 8'h00);
    settle();
    chk("rw_rd_ack", 32'(br.io_a_ack), 1);
    tick();
    set_a(0, 0, 13'h0000, 8'h00);
    settle();
    chk("rw_rd_valid", 32'(br.io_a_valid), 1);
    chk("rw_rd_dout",  32'(br.io_a_dout),  32'hC3);

    // A read 0x0000 then B read 0x0001 on consecutive cycles.
    tick();
    set_a(0, 1, 13'h0000, 8'h11);
    tick();
    set_a(0, 0, 13'h0000, 8'h00);
    set_b(0, 1, 13'h0001, 8'h22);
    tick();
    set_b(0, 0, 13'h0000, 8'h00);
    set_a(1, 0, 13'h0000, 8'h00);
    settle();
    chk("bb_a_ack",  32'(br.io_a_ack),    1);
    chk("bb_addr0",  32'(br.io_ram_addr), 32'h0000);
    tick();
    set_a(0, 0, 13'h0000, 8'h00);
    set_b(1, 0, 13'h0001, 8'h00);
    settle();
    chk("bb_b_ack",   32'(br.io_b_ack),    1);
    chk("bb_addr1",   32'(br.io_ram_addr), 32'h0001);
    chk("bb_a_valid", 32'(br.io_a_valid),  1);
    chk("bb_a_dout",  32'(br.io_a_dout),   32'h11);
    tick();
    set_b(0, 0, 13'h0000, 8'h00);
    settle();
    chk("bb_b_valid", 32'(br.io_b_valid), 1);
    chk("bb_a_vlow",  32'(br.io_a_valid), 0);
    chk("bb_b_dout",  32'(br.io_b_dout),  32'h22);

    // Reset in the cycle after a B read ack cancels the valid.
    tick();
    set_b(1, 0, 13'h0001, 8'h00);
    settle();
    chk("rm_b_ack", 32'(br.io_b_ack), 1);
    tick();
    set_b(0, 0, 13'h0000, 8'h00);
    reset = 1'b0;
    settle();
    chk("rm_b_valid_rst", 32'(br.io_b_valid), 0);
    tick();
    settle();
    chk("rm_b_valid_rst2", 32'(br.io_b_valid), 0);
    tick();
    reset = 1'b1;
    settle();
    chk("rm_b_valid_post", 32'(br.io_b_valid), 0);
    tick();
    set_a(1, 0, 13'h0010, 8'h00);
    set_b(1, 0, 13'h0020, 8'h00);
    settle();
    chk("rm_b_valid_post2", 32'(br.io_b_valid), 0);
    chk("rm_first_a",       32'(br.io_a_ack),   1);
    chk("rm_first_b",       32'(br.io_b_ack),   0);
    tick();
    idle_all();

    // Fixed priority: A held, B pending; B only once A drops.
    bf.io_a_rd = 1; bf.io_a_addr = 13'h0005;
    bf.io_b_rd = 1; bf.io_b_addr = 13'h0006;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("fp_a_ack%0d", k), 32'(bf.io_a_ack), 1);
      chk($sformatf("fp_b_ack%0d", k), 32'(bf.io_b_ack), 0);
      tick();
    end
    bf.io_a_rd = 0;
    settle();
    chk("fp_b_ack_free", 32'(bf.io_b_ack),    1);
    chk("fp_a_ack_free", 32'(bf.io_a_ack),    0);
    chk("fp_addr_b",     32'(bf.io_ram_addr), 32'h0006);
    tick();
    idle_all();
    settle();
    chk("fp_b_valid", 32'(bf.io_b_valid), 1);
    chk("fp_a_valid", 32'(bf.io_a_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, which sets the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which sets the RAM data width.
REQ-003 The block SHALL have parameter PRIORITY_A, default 0; 0 selects round-robin arbitration, 1 gives requester A fixed priority.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports io_a_rd and io_a_wr, inputs, 1 bit each: requester A read and write strobes, held until acknowledged.
REQ-007 The block SHALL have ports io_a_addr (ADDR_WIDTH) and io_a_din (DATA_WIDTH), inputs: requester A address and write data.
REQ-008 The block SHALL have port io_a_ack, output, 1 bit: requester A command accepted this cycle.
REQ-009 The block SHALL have ports io_a_valid, output, 1 bit, and io_a_dout, output, DATA_WIDTH: requester A read data strobe and data.
REQ-010 The block SHALL have ports io_b_* identical to REQ-006..REQ-009 for requester B.
REQ-011 The block SHALL have ports io_ram_rd, io_ram_wr (1 bit), io_ram_addr (ADDR_WIDTH) and io_ram_din (DATA_WIDTH), outputs: the command to the single-port RAM.
REQ-012 The block SHALL have port io_ram_dout, input, DATA_WIDTH: RAM read data, valid one cycle after io_ram_rd.

Function
REQ-013 A requester SHALL be pending when its rd or wr strobe is high.
REQ-014 At most one requester SHALL be granted per cycle; the grant is combinational on the pending strobes and the registered arbitration state.
REQ-015 In the grant cycle the granted requester's ack SHALL be high, and its strobes, addr and din SHALL drive io_ram_* in that same cycle.
REQ-016 With no grant, io_ram_rd, io_ram_wr, io_ram_addr and io_ram_din SHALL all be 0.
REQ-017 Round-robin (PRIORITY_A=0):
  - a single pending requester SHALL be granted;
  - when both are pending, the requester not granted last SHALL win;
  - register last_grant SHALL update only on a grant.
REQ-018 Fixed priority (PRIORITY_A=1): A SHALL win whenever it is pending; B SHALL be granted only when A is idle.
REQ-019 If rd and wr are both high on one requester, the write SHALL be issued and the read dropped; ack SHALL still pulse once.
REQ-020 A read grant SHALL set register rd_owner (A/B) and rd_pending; in the next cycle that owner's valid SHALL be high for exactly one cycle.
REQ-021 While valid is high, dout SHALL equal io_ram_dout; read latency from ack to valid is exactly 1 cycle.
REQ-022 The non-owner's valid SHALL stay 0; both dout outputs SHALL pass io_ram_dout unqualified.
REQ-023 Back-to-back grants, including a read followed by a read from the other requester, SHALL be issued on consecutive cycles; throughput is 1 command/cycle.
REQ-024 A requester that keeps its strobe high after ack SHALL be treated as a new request (no deduplication).

Reset
REQ-025 While reset is low:
  - last_grant SHALL be B, so that A wins the first contention;
  - rd_pending SHALL be 0 and rd_owner SHALL be A;
  - all acks and valids SHALL be 0.
REQ-026 Reset asserted mid-read SHALL cancel the pending valid; no valid SHALL appear after reset deasserts.

Structure
REQ-027 The owner encoding (A=0, B=1) SHALL be defined in the shared cave package alongside the RAM width constants.
REQ-028 The arbitration decision SHALL be a natural sub-module, rr_arbiter2 (two-way round-robin with a priority override); the read-return tracking stays in ram_arbiter.

Verification
REQ-029 A writes 0x5A to 0x0010 while B is idle, then A reads 0x0010 -> a_ack in each command cycle; a_valid one cycle after the read ack with a_dout=0x5A; b_valid stays 0.
REQ-030 A and B both read continuously with PRIORITY_A=0 -> grants alternate A,B,A,B starting with A after reset; each valid pulse follows its own ack by 1 cycle.
REQ-031 PRIORITY_A=1, A held continuously, B pending -> b_ack never asserts until A drops; B is granted in the first cycle A is idle.
REQ-032 A asserts rd and wr together at 0x1FFF with din 0xC3 -> one ack, ram_wr=1 and ram_rd=0; a_valid never asserts; a later read of 0x1FFF returns 0xC3.
REQ-033 Reset pulled low in the cycle after a B read ack -> b_valid stays 0 throughout and after reset; the first post-reset contention grants A.
REQ-034 A read of 0x0000 by A immediately followed by a read of 0x0001 by B -> io_ram_addr is 0x0000 then 0x0001 on consecutive cycles; a_valid then b_valid on consecutive cycles with the correct data.
